// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM; CTRL_RETIRE_CNT_EN adds the retired-instruction counter
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pcwr,
  output logic [1:0]  pcsrc,
  output logic        irwr,
  output logic        regwr,
  output logic [1:0]  regdst,
  output logic [1:0]  memtoreg,
  output logic        alusrc,
  output logic [2:0]  aluop,
  output logic        memrd,
  output logic        memwr,
  output logic        illegal
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  state_t state, next_state;

  logic is_rtype, is_j, is_jal, is_beq, is_bne, is_addi, is_xori, is_lw, is_sw;
  logic is_jr, is_add, is_sub, is_slt, is_legal;

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_xori  = (opcode == OP_XORI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_add   = is_rtype && (funct == FN_ADD);
  assign is_sub   = is_rtype && (funct == FN_SUB);
  assign is_slt   = is_rtype && (funct == FN_SLT);
  assign is_legal = is_j | is_jal | is_beq | is_bne | is_addi | is_xori | is_lw | is_sw |
                    is_jr | is_add | is_sub | is_slt;

  // State register; reset abandons any in-flight access by returning to START
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= START;
    else          state <= next_state;
  end

  // Next-state and per-state control outputs
  always_comb begin
    next_state = state;
    pcwr       = 1'b0;
    pcsrc      = 2'b00;
    irwr       = 1'b0;
    regwr      = 1'b0;
    regdst     = 2'b00;
    memtoreg   = 2'b00;
    alusrc     = 1'b0;
    aluop      = 3'b000;
    memrd      = 1'b0;
    memwr      = 1'b0;
    illegal    = 1'b0;
    case (state)
      START: next_state = FETCH;
      FETCH: begin
        irwr       = 1'b1;
        pcwr       = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        if (!is_legal) begin
          illegal    = 1'b1;
          next_state = FETCH;
        end else if (is_j) begin
          pcwr       = 1'b1;
          pcsrc      = 2'b10;
          next_state = FETCH;
        end else if (is_jal) begin
          pcwr       = 1'b1;
          pcsrc      = 2'b10;
          regwr      = 1'b1;
          regdst     = 2'b10;
          memtoreg   = 2'b10;
          next_state = FETCH;
        end else if (is_jr) begin
          pcwr       = 1'b1;
          pcsrc      = 2'b11;
          next_state = FETCH;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (is_sub || is_beq || is_bne) aluop = 3'b001;
        else if (is_xori)               aluop = 3'b010;
        else if (is_slt)                aluop = 3'b011;
        else                            aluop = 3'b000;
        alusrc = is_addi | is_xori | is_lw | is_sw;
        if (is_beq || is_bne) begin
          // Branch decision is the only output that follows an input combinationally
          pcwr       = is_beq ? zero : ~zero;
          pcsrc      = 2'b01;
          next_state = FETCH;
        end else if (is_lw || is_sw) begin
          next_state = MEM;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        memrd = is_lw;
        memwr = is_sw;
        if (mem_ready) next_state = is_lw ? WB : FETCH;
      end
      WB: begin
        regwr      = 1'b1;
        regdst     = is_rtype ? 2'b01 : 2'b00;
        memtoreg   = is_lw ? 2'b01 : 2'b00;
        next_state = FETCH;
      end
      default: next_state = START;
    endcase
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
  logic        retiring;

  assign retiring = (next_state == FETCH) &&
                    ((state == DECODE) || (state == EXEC) || (state == MEM) || (state == WB));

  // Count every instruction that completes, including illegal ones and untaken branches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      retired_cnt <= 32'd0;
    else if (retiring) retired_cnt <= retired_cnt + 32'd1;
  end

  assign retired = retired_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl (CTRL_RETIRE_CNT_EN optional)
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pcwr, irwr, regwr, alusrc, memrd, memwr, illegal;
  logic [1:0]  pcsrc, regdst, memtoreg;
  logic [2:0]  aluop;
`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  multicycle_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pcwr      (pcwr),
    .pcsrc     (pcsrc),
    .irwr      (irwr),
    .regwr     (regwr),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .alusrc    (alusrc),
    .aluop     (aluop),
    .memrd     (memrd),
    .memwr     (memwr),
    .illegal   (illegal)
`ifdef CTRL_RETIRE_CNT_EN
    ,
    .retired   (retired)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] act;
  assign act = {pcwr, pcsrc, irwr, regwr, regdst, memtoreg, alusrc, aluop, memrd, memwr, illegal};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_vec = '0;
  logic        exp_on = 1'b0;
  string       cur_tag = "reset";
  int          cyc_idx;
  int          c_cyc, c_rd, c_wr, c_rw;
  logic [15:0] exp_q[$];

  // Per-cycle comparison of the DUT against the model's expected vector
  always @(negedge clk) begin
    if (exp_on) begin
      n_cmp++;
      if (act !== exp_vec) begin
        n_bad++;
        $display("FAIL %s cycle %0d actual=%h required=%h", cur_tag, cyc_idx, act, exp_vec);
      end
      c_cyc++;
      c_rd += int'(memrd);
      c_wr += int'(memwr);
      c_rw += int'(regwr);
    end
  end

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  function automatic logic [15:0] v(input logic pw, input logic [1:0] ps, input logic ir,
                                    input logic rw, input logic [1:0] rd, input logic [1:0] mt,
                                    input logic as, input logic [2:0] ao, input logic mr,
                                    input logic mw, input logic il);
    return {pw, ps, ir, rw, rd, mt, as, ao, mr, mw, il};
  endfunction

  // Instruction-level model: the cycle-by-cycle control vectors one instruction must produce
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int stalls);
    logic       ld, st, br, imm, rt;
    logic [2:0] ao;
    ld = 0; st = 0; br = 0; imm = 0; rt = 0; ao = 3'd0;
    exp_q.delete();
    exp_q.push_back(v(1, 2'd0, 1, 0, 2'd0, 2'd0, 0, 3'd0, 0, 0, 0));
    case (op)
      OP_J:   begin exp_q.push_back(v(1, 2'd2, 0, 0, 2'd0, 2'd0, 0, 3'd0, 0, 0, 0)); return; end
      OP_JAL: begin exp_q.push_back(v(1, 2'd2, 0, 1, 2'd2, 2'd2, 0, 3'd0, 0, 0, 0)); return; end
      OP_RTYPE: begin
        rt = 1;
        case (fn)
          FN_JR:  begin exp_q.push_back(v(1, 2'd3, 0, 0, 2'd0, 2'd0, 0, 3'd0, 0, 0, 0)); return; end
          FN_ADD: ao = 3'd0;
          FN_SUB: ao = 3'd1;
          FN_SLT: ao = 3'd3;
          default: begin exp_q.push_back(v(0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 0, 0, 1)); return; end
        endcase
      end
      OP_LW:   begin ld = 1; imm = 1; end
      OP_SW:   begin st = 1; imm = 1; end
      OP_ADDI: imm = 1;
      OP_XORI: begin imm = 1; ao = 3'd2; end
      OP_BEQ, OP_BNE: begin br = 1; ao = 3'd1; end
      default: begin exp_q.push_back(v(0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 0, 0, 1)); return; end
    endcase
    exp_q.push_back('0);
    if (br) begin
      exp_q.push_back(v((op == OP_BEQ) ? z : !z, 2'd1, 0, 0, 2'd0, 2'd0, 0, ao, 0, 0, 0));
      return;
    end
    exp_q.push_back(v(0, 2'd0, 0, 0, 2'd0, 2'd0, imm, ao, 0, 0, 0));
    if (ld || st)
      for (int k = 0; k <= stalls; k++) exp_q.push_back(v(0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 3'd0, ld, st, 0));
    if (!st) exp_q.push_back(v(0, 2'd0, 0, 1, rt ? 2'd1 : 2'd0, ld ? 2'd1 : 2'd0, 0, 3'd0, 0, 0, 0));
  endtask

  // Runs one instruction from its FETCH cycle; limit < 0 runs it to completion
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int stalls, input int limit);
    build(op, fn, z, stalls);
    cur_tag = tag;
    opcode = op; funct = fn; zero = z;
    c_cyc = 0; c_rd = 0; c_wr = 0; c_rw = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (limit >= 0 && i >= limit) break;
      cyc_idx   = i;
      exp_vec   = exp_q[i];
      mem_ready = (i >= 3 && i < 3 + stalls) ? 1'b0 : 1'b1;
      exp_on    = 1'b1;
      @(posedge clk); #1;
    end
    exp_on = 1'b0;
  endtask

  // START cycle right after reset release: all outputs 0, mem_ready high is ignored
  task automatic start_cycle();
    cur_tag = "start"; cyc_idx = 0;
    exp_vec = '0; mem_ready = 1'b1; exp_on = 1'b1;
    @(posedge clk); #1;
    exp_on = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(act), 32'h0);
    reset_n = 1'b1;
    start_cycle();

    run("add", OP_RTYPE, FN_ADD, 0, 0, -1);
    check("add_cycles", c_cyc, 4);
    check("add_regwr_cycles", c_rw, 1);
    run("sub", OP_RTYPE, FN_SUB, 1, 0, -1);
    run("slt", OP_RTYPE, FN_SLT, 0, 0, -1);
    run("addi", OP_ADDI, 6'h15, 0, 0, -1);
    run("xori", OP_XORI, 6'h2a, 1, 0, -1);
    run("lw", OP_LW, 6'h00, 0, 0, -1);
    check("lw_cycles", c_cyc, 5);
    run("lw_stall3", OP_LW, 6'h11, 0, 3, -1);
    check("lw_stall3_cycles", c_cyc, 8);
    check("lw_stall3_memrd_cycles", c_rd, 4);
    run("sw", OP_SW, 6'h00, 0, 0, -1);
    check("sw_cycles", c_cyc, 4);
    check("sw_memwr_cycles", c_wr, 1);
    check("sw_regwr_cycles", c_rw, 0);
    run("sw_stall2", OP_SW, 6'h00, 1, 2, -1);
    run("beq_taken", OP_BEQ, 6'h00, 1, 0, -1);
    check("beq_cycles", c_cyc, 3);
    run("beq_not_taken", OP_BEQ, 6'h00, 0, 0, -1);
    run("bne_taken", OP_BNE, 6'h00, 0, 0, -1);
    run("bne_not_taken", OP_BNE, 6'h00, 1, 0, -1);
    run("j", OP_J, 6'h00, 0, 0, -1);
    check("j_cycles", c_cyc, 2);
    run("jal", OP_JAL, 6'h00, 0, 0, -1);
    run("jr", OP_RTYPE, FN_JR, 0, 0, -1);
    check("jr_regwr_cycles", c_rw, 0);
    run("illegal_op", 6'b111111, 6'h00, 0, 0, -1);
    run("illegal_funct", OP_RTYPE, 6'b000111, 0, 0, -1);
    run("after_illegal", OP_RTYPE, FN_ADD, 0, 0, -1);

    // Stalled SW, then drop reset in its second MEM cycle
    run("sw_abort", OP_SW, 6'h00, 0, 5, 4);
    check("sw_abort_memwr_before", 32'(memwr), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("sw_abort_memwr_async", 32'(memwr), 32'h0);
    check("sw_abort_outputs_async", 32'(act), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    start_cycle();
    run("post_reset_add", OP_RTYPE, FN_ADD, 0, 0, -1);

`ifdef CTRL_RETIRE_CNT_EN
    check("retired_after_one", retired, 32'd1);
    run("r_illegal", 6'b111111, 6'h00, 0, 0, -1);
    run("r_beq_nt", OP_BEQ, 6'h00, 0, 0, -1);
    run("r_lw", OP_LW, 6'h00, 0, 1, -1);
    run("r_j", OP_J, 6'h00, 0, 0, -1);
    check("retired_after_five", retired, 32'd5);
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1 release dut.retired_cnt;
    #1 check("retired_preset", retired, 32'hFFFF_FFFF);
    run("r_wrap", OP_J, 6'h00, 0, 0, -1);
    check("retired_wrap", retired, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multicycle MIPS-subset datapath. It sequences a shared ALU, register file, PC and data-memory port through FETCH/DECODE/EXEC/MEM/WB. Each step is driven by the instruction-register opcode/funct fields, the ALU zero flag and a data-memory ready handshake. It emits per-cycle write enables and mux selects, replacing the per-signal combinational lookups used by the single-cycle core.

## Interface
- No parameters. Opcode and funct values come from the shared decode header macros: LW, SW, J, JAL, BEQ, BNE, XORI, ADDI, RTYPE; funct JR, ADD, SUB, SLT.
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  data memory has completed the current access
- pcwr  out  1  PC write enable
- pcsrc  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs register
- irwr  out  1  instruction register write enable
- regwr  out  1  register file write enable
- regdst  out  2  00 rt, 01 rd, 10 r31
- memtoreg  out  2  00 ALU result, 01 memory data, 10 PC (link)
- alusrc  out  1  0 register rt, 1 sign-extended immediate
- aluop  out  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
- memrd  out  1  data memory read request
- memwr  out  1  data memory write request
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode or funct

## Operation
- States: START, FETCH, DECODE, EXEC, MEM, WB. Reset forces START.
- START: all outputs 0. Goes to FETCH next cycle.
- FETCH: irwr=1, pcwr=1, pcsrc=00. Goes to DECODE.
- DECODE:
  - J: pcwr=1, pcsrc=10.
  - JAL: pcwr=1, pcsrc=10, regwr=1, regdst=10, memtoreg=10.
  - RTYPE+JR: pcwr=1, pcsrc=11.
  - J, JAL and JR go to FETCH.
  - Illegal: illegal=1, no writes, go to FETCH.
  - All others go to EXEC.
- EXEC:
  - ADD/ADDI/LW/SW use aluop=000. SUB/BEQ/BNE use 001. XORI uses 010. SLT uses 011.
  - alusrc=1 for ADDI/XORI/LW/SW, else 0.
  - BEQ: pcwr=zero. BNE: pcwr=~zero. Both use pcsrc=01 and then go to FETCH.
  - LW/SW go to MEM. R-type/ADDI/XORI go to WB.
- MEM:
  - memrd=1 (LW) or memwr=1 (SW), held while mem_ready=0.
  - On mem_ready=1: LW goes to WB, SW goes to FETCH.
- WB: regwr=1. R-type: regdst=01, memtoreg=00. ADDI/XORI: regdst=00, memtoreg=00. LW: regdst=00, memtoreg=01. Then FETCH.
- Any output not listed for a state is 0.
- All outputs are Moore (state + opcode/funct), except EXEC pcwr, which follows zero combinationally.

## Timing
- Cycles per instruction, FETCH through last state, with mem_ready=1 on the first MEM cycle:
  - J, JAL, JR: 2
  - BEQ, BNE: 3
  - R-type, ADDI, XORI: 4
  - SW: 4
  - LW: 5
- Each cycle mem_ready is low adds one MEM cycle.
- mem_ready is sampled only in MEM; a high level in any other state is ignored.
- memrd/memwr stay stable until the edge on which mem_ready=1 is sampled, then drop.
- reset_n low at any time, including mid-MEM, clears the state to START. All outputs go to 0 asynchronously with no further edge; the abandoned access is not completed.
- After reset_n rises: first FETCH at the second rising edge (START lasts one cycle).

## Configuration
- CTRL_RETIRE_CNT_EN defined:
  - Adds output port retired [31:0], reset value 0.
  - Increments by 1 on every edge where the state goes to FETCH from DECODE, EXEC, MEM or WB, including illegal instructions and untaken branches.
  - Wraps from 0xFFFFFFFF to 0.
- CTRL_RETIRE_CNT_EN undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset with reset_n=0, then release -> all outputs 0; irwr=pcwr=1 exactly on the 2nd cycle after release.
- ADD (RTYPE, funct 100000) -> 4-cycle sequence; aluop=000 in EXEC; regwr=1, regdst=01, memtoreg=00 only in WB.
- LW with mem_ready low for 3 MEM cycles -> memrd=1 for 4 cycles, then WB with regwr=1, memtoreg=01; total 8 cycles. SW with mem_ready=1 -> 4 cycles, memwr=1 for 1 cycle, regwr never 1.
- BEQ with zero=1 -> pcwr=1, pcsrc=01 in EXEC. BEQ with zero=0 -> pcwr=0. BNE gives the inverse. All take 3 cycles.
- JAL -> DECODE: pcwr=1, pcsrc=10, regwr=1, regdst=10, memtoreg=10. JR -> pcsrc=11, regwr=0. Opcode 111111 -> illegal pulse, then FETCH.
- reset_n dropped in MEM of a stalled SW -> memwr goes to 0 before the next edge. With CTRL_RETIRE_CNT_EN defined, retired counts 5 after five instructions and wraps from 0xFFFFFFFF to 0.
